// File: rtl/regfile_wr_arbiter_if.sv
// Write-port bundle between the two writeback requesters and the register file arbiter.
// master: requester / register-file side; slave: the arbiter.
interface regfile_wr_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  REQ0_VALID;
  logic [ADDR_WIDTH-1:0] REQ0_ADDR;
  logic [DATA_WIDTH-1:0] REQ0_DATA;
  logic                  REQ0_READY;
  logic                  REQ1_VALID;
  logic [ADDR_WIDTH-1:0] REQ1_ADDR;
  logic [DATA_WIDTH-1:0] REQ1_DATA;
  logic                  REQ1_READY;
  logic [ADDR_WIDTH-1:0] A3;
  logic [DATA_WIDTH-1:0] WD3;
  logic                  WE3;
  logic                  BUSY;

  modport master (
    output REQ0_VALID, REQ0_ADDR, REQ0_DATA,
    output REQ1_VALID, REQ1_ADDR, REQ1_DATA,
    input  REQ0_READY, REQ1_READY,
    input  A3, WD3, WE3, BUSY
  );

  modport slave (
    input  REQ0_VALID, REQ0_ADDR, REQ0_DATA,
    input  REQ1_VALID, REQ1_ADDR, REQ1_DATA,
    output REQ0_READY, REQ1_READY,
    output A3, WD3, WE3, BUSY
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin owner of the register file write port; writes to $0 are dropped.
// Define REGFILE_CLEAR_EN to zero the whole file with a sweep after every reset.
module regfile_wr_arbiter #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 32
) (
  input logic                 CLK,
  input logic                 RST,
  regfile_wr_arbiter_if.slave bus
);

  if (NUM_REGS != (1 << ADDR_WIDTH)) begin : g_bad_num_regs
    $error("NUM_REGS must equal 2**ADDR_WIDTH");
  end

  logic [ADDR_WIDTH-1:0] a3_q;
  logic [DATA_WIDTH-1:0] wd3_q;
  logic                  we3_q;
  logic                  last_q;   // 1: requester 1 won the last transfer
  logic                  arb_en;
  logic                  gnt0, gnt1, xfer;
  logic [ADDR_WIDTH-1:0] xfer_addr;
  logic [DATA_WIDTH-1:0] xfer_data;

`ifdef REGFILE_CLEAR_EN
  typedef enum logic [0:0] {StClear, StArb} state_e;
  state_e                state_q;
  logic [ADDR_WIDTH-1:0] clr_cnt_q;
  logic                  busy_q;

  assign arb_en   = (state_q == StArb);
  assign bus.BUSY = busy_q;
`else
  assign arb_en   = 1'b1;
  assign bus.BUSY = 1'b0;
`endif

  // Grant is held off during the reset cycle so no handshake completes then.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (arb_en && !RST) begin
      if (bus.REQ0_VALID && (!bus.REQ1_VALID || last_q)) begin
        gnt0 = 1'b1;
      end else if (bus.REQ1_VALID) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign xfer      = gnt0 | gnt1;
  assign xfer_addr = gnt1 ? bus.REQ1_ADDR : bus.REQ0_ADDR;
  assign xfer_data = gnt1 ? bus.REQ1_DATA : bus.REQ0_DATA;

  assign bus.REQ0_READY = gnt0;
  assign bus.REQ1_READY = gnt1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      a3_q   <= '0;
      wd3_q  <= '0;
      we3_q  <= 1'b0;
      last_q <= 1'b1;
`ifdef REGFILE_CLEAR_EN
      state_q   <= StClear;
      clr_cnt_q <= '0;
      busy_q    <= 1'b1;
    end else if (state_q == StClear) begin
      we3_q     <= 1'b1;
      a3_q      <= clr_cnt_q;
      wd3_q     <= '0;
      clr_cnt_q <= clr_cnt_q + ADDR_WIDTH'(1);
      if (clr_cnt_q == ADDR_WIDTH'(NUM_REGS - 1)) begin
        state_q <= StArb;
        busy_q  <= 1'b0;
      end
`endif
    end else begin
      // Writes to $0 are accepted but never reach the file.
      we3_q <= xfer && (xfer_addr != '0);
      if (xfer) begin
        a3_q   <= xfer_addr;
        wd3_q  <= xfer_data;
        last_q <= gnt1;
      end
    end
  end

  assign bus.A3  = a3_q;
  assign bus.WD3 = wd3_q;
  assign bus.WE3 = we3_q;

endmodule
